// File: rtl/half_word_packer_pkg.sv
// half_word_packer_pkg: shared widths and FSM state type for the half-word packer
package half_word_packer_pkg;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    typedef enum logic {LO, HI} state_t;
endpackage

// File: rtl/packer_fifo.sv
// packer_fifo: synchronous FIFO (power-of-two depth) whose head reads as zero when empty
module packer_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic do_push, do_pop;
    assign do_push = push && count != FULL;
    assign do_pop = pop && count != '0;
    assign head = count == '0 ? '0 : mem[rd];
    // storage array, written at the tail on an accepted push
    always_ff @(posedge clock) begin
        if (do_push) mem[wr] <= din;
    end
    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/half_word_packer.sv
// half_word_packer: joins low/high 16-bit halves into 32-bit words queued for a valid/ready consumer; HALF_WORD_PACKER_PARITY_EN adds out_par
module half_word_packer
    import half_word_packer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [HALF_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
`ifdef HALF_WORD_PACKER_PARITY_EN
    ,
    output logic              out_par
`endif
);
`ifdef HALF_WORD_PACKER_PARITY_EN
    localparam int FW = WORD_W + 1;
`else
    localparam int FW = WORD_W;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t state, nstate;
    logic [HALF_W-1:0] lo_reg;
    logic [AW:0] count;
    logic [FW-1:0] head, din;
    logic push, load;
`ifdef HALF_WORD_PACKER_PARITY_EN
    assign din = {^{in_data, lo_reg}, in_data, lo_reg};
    assign out_par = head[WORD_W];
`else
    assign din = {in_data, lo_reg};
`endif
    assign out_valid = count != '0;
    assign out_data = head[WORD_W-1:0];
    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= LO;
        else state <= nstate;
    end
    // next state: flush always returns to LO and overrides any arriving half
    always_comb begin
        nstate = flush ? LO : (state == LO && in_valid) ? HI : push ? LO : state;
    end
    // handshake outputs come from registered state only, never from out_ready
    always_comb begin
        in_ready = state == LO || count != FULL;
        push = state == HI && in_valid && in_ready && !flush;
        load = state == LO && in_valid && !flush;
    end
    // pending low half and completed-word counter
    always_ff @(posedge clock) begin
        if (reset || flush) lo_reg <= '0;
        else if (load) lo_reg <= in_data;
        if (reset) word_cnt <= '0;
        else if (push) word_cnt <= word_cnt + 1'b1;
    end
    packer_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (out_valid && out_ready),
        .din   (din),
        .head  (head),
        .count (count)
    );
endmodule
